// File: rtl/cascade_rom_sequencer_if.sv
// Bus between the window scheduler, the cascade ROM address sequencer and
// the ROM / weak-classifier evaluator. Signal names carry the direction as
// seen from the sequencer.
interface cascade_rom_sequencer_if #(
    parameter int ADDR_WIDTH      = 15,
    parameter int STAGE_IDX_WIDTH = 5
);
    // Run-time configuration of the stage-threshold table.
    logic                       cfg_we_i;
    logic [STAGE_IDX_WIDTH-1:0] cfg_idx_i;
    logic [ADDR_WIDTH-1:0]      cfg_addr_i;
    logic                       cfg_last_we_i;
    logic [STAGE_IDX_WIDTH-1:0] cfg_last_i;

    // Window scheduler handshake.
    logic                       start_i;
    logic                       break_i;
    logic                       wait_i;
    logic                       next_stage_i;
    logic                       busy_o;
    logic                       done_o;

    // ROM side.
    logic [ADDR_WIDTH-1:0]      rom_addr_o;
    logic                       rom_req_o;
    logic                       rom_val_o;
    logic                       stage_val_o;
    logic                       stage_last_o;
    logic [STAGE_IDX_WIDTH-1:0] stage_idx_o;

    // Sequencer side.
    modport slave (
        input  cfg_we_i, cfg_idx_i, cfg_addr_i, cfg_last_we_i, cfg_last_i,
        input  start_i, break_i, wait_i, next_stage_i,
        output busy_o, done_o,
        output rom_addr_o, rom_req_o, rom_val_o, stage_val_o, stage_last_o, stage_idx_o
    );

    // Scheduler / evaluator side.
    modport master (
        output cfg_we_i, cfg_idx_i, cfg_addr_i, cfg_last_we_i, cfg_last_i,
        output start_i, break_i, wait_i, next_stage_i,
        input  busy_o, done_o,
        input  rom_addr_o, rom_req_o, rom_val_o, stage_val_o, stage_last_o, stage_idx_o
    );
endinterface

// File: rtl/cascade_rom_sequencer.sv
// Address sequencer for the classifier-cascade ROM. Walks one detection
// window through the weak-classifier words of each stage, issues the
// stage-threshold word, then waits for the stage decision. Returns from the
// ROM are tracked through a ROM_LATENCY-deep tag pipeline so the evaluator
// knows whether a word is classifier data or a threshold.
module cascade_rom_sequencer #(
    parameter int ADDR_WIDTH      = 15,
    parameter int STAGE_CNT_MAX   = 32,
    parameter int STAGE_IDX_WIDTH = $clog2(STAGE_CNT_MAX),
    parameter int ROM_LATENCY     = 1
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    cascade_rom_sequencer_if.slave   bus_if
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_DECIDE
    } state_t;

    state_t                     state_q;
    logic [ADDR_WIDTH-1:0]      addr_q;
    logic [STAGE_IDX_WIDTH-1:0] stage_q;
    logic [STAGE_IDX_WIDTH-1:0] last_q;
    logic [ADDR_WIDTH-1:0]      thr_tbl_q [STAGE_CNT_MAX];
    logic [ROM_LATENCY-1:0]     pipe_vld_q;
    logic [ROM_LATENCY-1:0]     pipe_thr_q;
    logic                       thr_seen_q;
    logic                       done_q;

    logic issue;
    logic thr_hit;
    logic ret_vld;
    logic ret_thr;
    logic accept;

    // Issue decision, threshold match and decision acceptance for this cycle.
    always_comb begin
        issue   = (state_q == ST_RUN) && !bus_if.wait_i;
        thr_hit = (addr_q == thr_tbl_q[stage_q]);
        ret_vld = pipe_vld_q[ROM_LATENCY-1];
        ret_thr = pipe_thr_q[ROM_LATENCY-1];
        // A decision only counts once the threshold word has come back.
        accept  = (state_q == ST_DECIDE) && bus_if.next_stage_i &&
                  (thr_seen_q || (ret_vld && ret_thr));
    end

    assign bus_if.busy_o       = (state_q != ST_IDLE);
    assign bus_if.rom_req_o    = issue;
    assign bus_if.rom_addr_o   = addr_q;
    assign bus_if.rom_val_o    = ret_vld && !ret_thr;
    assign bus_if.stage_val_o  = ret_vld && ret_thr;
    assign bus_if.stage_last_o = ret_vld && ret_thr && (stage_q == last_q);
    assign bus_if.stage_idx_o  = stage_q;
    assign bus_if.done_o       = done_q;

    // Sequencer FSM, threshold table, return-tag pipeline and done pulse.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q    <= ST_IDLE;
            addr_q     <= '0;
            stage_q    <= '0;
            last_q     <= '0;
            pipe_vld_q <= '0;
            pipe_thr_q <= '0;
            thr_seen_q <= 1'b0;
            done_q     <= 1'b0;
            for (int i = 0; i < STAGE_CNT_MAX; i++) begin
                thr_tbl_q[i] <= '0;
            end
        end else begin
            done_q <= 1'b0;

            // Tag pipeline: the oldest entry is what the ROM presents now.
            pipe_vld_q[0] <= issue;
            pipe_thr_q[0] <= issue && thr_hit;
            for (int i = 1; i < ROM_LATENCY; i++) begin
                pipe_vld_q[i] <= pipe_vld_q[i-1];
                pipe_thr_q[i] <= pipe_thr_q[i-1];
            end

            if (bus_if.break_i) begin
                // Abort: in-flight returns are discarded so nothing reaches the evaluator.
                state_q    <= ST_IDLE;
                addr_q     <= '0;
                stage_q    <= '0;
                thr_seen_q <= 1'b0;
                pipe_vld_q <= '0;
            end else begin
                unique case (state_q)
                    ST_IDLE: begin
                        if (bus_if.cfg_we_i) begin
                            thr_tbl_q[bus_if.cfg_idx_i] <= bus_if.cfg_addr_i;
                        end
                        if (bus_if.cfg_last_we_i) begin
                            last_q <= bus_if.cfg_last_i;
                        end
                        if (bus_if.start_i) begin
                            state_q <= ST_RUN;
                            addr_q  <= '0;
                            stage_q <= '0;
                        end
                    end
                    ST_RUN: begin
                        if (issue) begin
                            if (thr_hit) begin
                                // Hold the address on the threshold word while deciding.
                                state_q    <= ST_DECIDE;
                                thr_seen_q <= 1'b0;
                            end else begin
                                addr_q <= addr_q + ADDR_WIDTH'(1);
                            end
                        end
                    end
                    ST_DECIDE: begin
                        if (ret_vld && ret_thr) begin
                            thr_seen_q <= 1'b1;
                        end
                        if (accept) begin
                            thr_seen_q <= 1'b0;
                            if (stage_q == last_q) begin
                                done_q  <= 1'b1;
                                state_q <= ST_IDLE;
                                addr_q  <= '0;
                                stage_q <= '0;
                            end else begin
                                state_q <= ST_RUN;
                                addr_q  <= addr_q + ADDR_WIDTH'(1);
                                stage_q <= stage_q + STAGE_IDX_WIDTH'(1);
                            end
                        end
                    end
                    default: begin
                        state_q <= ST_IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_cascade_rom_sequencer.sv
// Testbench for cascade_rom_sequencer: three instances (ROM latency 1, 2, 3)
// share one stimulus stream and are compared every cycle against a
// transaction-level model of the sequencing rules, plus directed checks.
module tb_cascade_rom_sequencer;

    localparam int AW   = 15;
    localparam int SW   = 5;
    localparam int NDUT = 3;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic          cfg_we, cfg_last_we, start, brk, wt, ns;
    logic [SW-1:0] cfg_idx, cfg_last;
    logic [AW-1:0] cfg_addr;

    // {busy, req, val, stage_val, stage_last, done, stage_idx[4:0], addr[14:0]}
    logic [25:0] obs [NDUT];

    cascade_rom_sequencer_if #(.ADDR_WIDTH(AW), .STAGE_IDX_WIDTH(SW)) ifs [NDUT] ();

    genvar g;
    generate
        for (g = 0; g < NDUT; g++) begin : g_dut
            assign ifs[g].cfg_we_i      = cfg_we;
            assign ifs[g].cfg_idx_i     = cfg_idx;
            assign ifs[g].cfg_addr_i    = cfg_addr;
            assign ifs[g].cfg_last_we_i = cfg_last_we;
            assign ifs[g].cfg_last_i    = cfg_last;
            assign ifs[g].start_i       = start;
            assign ifs[g].break_i       = brk;
            assign ifs[g].wait_i        = wt;
            assign ifs[g].next_stage_i  = ns;
            assign obs[g] = {ifs[g].busy_o, ifs[g].rom_req_o, ifs[g].rom_val_o,
                             ifs[g].stage_val_o, ifs[g].stage_last_o, ifs[g].done_o,
                             ifs[g].stage_idx_o, ifs[g].rom_addr_o};
            cascade_rom_sequencer #(
                .ADDR_WIDTH(AW), .STAGE_CNT_MAX(32), .ROM_LATENCY(g + 1)
            ) u_dut (
                .clk_i (clk),
                .rst_i (rst),
                .bus_if(ifs[g])
            );
        end
    endgenerate

    int n_assert = 0;
    int n_fail   = 0;

    // Reference model: window progress per instance, returns scheduled by due cycle.
    int m_phase [NDUT];       // 0 idle, 1 issuing, 2 awaiting decision
    int m_addr  [NDUT];
    int m_stage [NDUT];
    bit m_seen  [NDUT];
    bit m_done  [NDUT];
    int m_last  [NDUT];
    int m_tbl   [NDUT][32];
    int m_ret   [NDUT][8];    // 0 none, 1 classifier word, 2 threshold word
    int cyc = 0;

    // Observation counters.
    int cnt_val [NDUT], cnt_sv [NDUT], cnt_last [NDUT], cnt_done [NDUT], cls_before [NDUT];
    bit got_sv  [NDUT];
    int issued0 [$];
    int stall5, thr_cyc, sv_cyc;

    task automatic chk(input string tag, input logic [31:0] o, input logic [31:0] e);
        n_assert++;
        assert (o === e) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, o, e);
        end
    endtask

    function automatic void model_reset();
        for (int k = 0; k < NDUT; k++) begin
            m_phase[k] = 0; m_addr[k] = 0; m_stage[k] = 0; m_seen[k] = 0;
            m_done[k] = 0; m_last[k] = 0;
            for (int i = 0; i < 32; i++) m_tbl[k][i] = 0;
            for (int i = 0; i < 8; i++) m_ret[k][i] = 0;
        end
    endfunction

    function automatic void clear_counts();
        for (int k = 0; k < NDUT; k++) begin
            cnt_val[k] = 0; cnt_sv[k] = 0; cnt_last[k] = 0; cnt_done[k] = 0;
            cls_before[k] = 0; got_sv[k] = 0;
        end
        issued0.delete();
        stall5 = 0;
    endfunction

    task automatic check_all();
        logic [25:0] e;
        for (int k = 0; k < NDUT; k++) begin
            e = {m_phase[k] != 0, (m_phase[k] == 1) && !wt,
                 m_ret[k][cyc % 8] == 1, m_ret[k][cyc % 8] == 2,
                 (m_ret[k][cyc % 8] == 2) && (m_stage[k] == m_last[k]),
                 m_done[k], SW'(m_stage[k]), AW'(m_addr[k])};
            n_assert++;
            assert (obs[k] === e) else begin
                n_fail++;
                $error("FAIL cycle%0d lat%0d outputs: observed %h expected %h", cyc, k + 1, obs[k], e);
            end
        end
    endtask

    task automatic observe();
        for (int k = 0; k < NDUT; k++) begin
            if (obs[k][23]) cnt_val[k]++;
            if (obs[k][23] && !got_sv[k]) cls_before[k]++;
            if (obs[k][22]) begin cnt_sv[k]++; got_sv[k] = 1; end
            if (obs[k][21]) cnt_last[k]++;
            if (obs[k][20]) cnt_done[k]++;
        end
        if (obs[0][24]) issued0.push_back(int'(obs[0][14:0]));
        if (obs[0][25] && !obs[0][24] && obs[0][14:0] == 15'd5) stall5++;
        if (obs[2][24] && obs[2][14:0] == 15'd2) thr_cyc = cyc;
    endtask

    function automatic void model_step();
        int sv, tag;
        for (int k = 0; k < NDUT; k++) begin
            sv = (m_ret[k][cyc % 8] == 2) ? 1 : 0;
            m_ret[k][cyc % 8] = 0;
            m_done[k] = 0;
            if (brk) begin
                m_phase[k] = 0; m_addr[k] = 0; m_stage[k] = 0; m_seen[k] = 0;
                for (int i = 0; i < 8; i++) m_ret[k][i] = 0;
            end else if (m_phase[k] == 0) begin
                if (cfg_we) m_tbl[k][cfg_idx] = int'(cfg_addr);
                if (cfg_last_we) m_last[k] = int'(cfg_last);
                if (start) begin m_phase[k] = 1; m_addr[k] = 0; m_stage[k] = 0; end
            end else if (m_phase[k] == 1) begin
                if (!wt) begin
                    tag = (m_addr[k] == m_tbl[k][m_stage[k]]) ? 2 : 1;
                    m_ret[k][(cyc + k + 1) % 8] = tag;
                    if (tag == 2) begin m_phase[k] = 2; m_seen[k] = 0; end
                    else m_addr[k] = (m_addr[k] + 1) % 32768;
                end
            end else begin
                if (ns && (m_seen[k] || sv == 1)) begin
                    m_seen[k] = 0;
                    if (m_stage[k] == m_last[k]) begin
                        m_done[k] = 1; m_phase[k] = 0; m_addr[k] = 0; m_stage[k] = 0;
                    end else begin
                        m_stage[k]++; m_addr[k] = (m_addr[k] + 1) % 32768; m_phase[k] = 1;
                    end
                end else if (sv == 1) begin
                    m_seen[k] = 1;
                end
            end
        end
    endfunction

    // One clock: check outputs under the current inputs, advance model and DUTs.
    task automatic cycle();
        #1;
        check_all();
        observe();
        model_step();
        @(posedge clk);
        cyc++;
        #1;
        start = 0; brk = 0; cfg_we = 0; cfg_last_we = 0;
    endtask

    task automatic write_entry(input int idx, input int a);
        cfg_we = 1; cfg_idx = SW'(idx); cfg_addr = AW'(a);
        cycle();
    endtask

    task automatic write_last(input int l);
        cfg_last_we = 1; cfg_last = SW'(l);
        cycle();
    endtask

    task automatic run_idle(input int budget);
        int n = 0;
        while ((m_phase[0] != 0 || m_phase[1] != 0 || m_phase[2] != 0) && n < budget) begin
            cycle();
            n++;
        end
        chk("run_idle_timeout", 32'(n < budget), 32'd1);
    endtask

    task automatic check_order0(input string tag, input int n);
        chk({tag, "_req_count"}, 32'(issued0.size()), 32'(n));
        for (int i = 0; i < issued0.size() && i < n; i++)
            chk({tag, "_req_addr"}, 32'(issued0[i]), 32'(i));
    endtask

    initial begin
        int n;
        bit hit;
        rst = 1; cfg_we = 0; cfg_last_we = 0; start = 0; brk = 0; wt = 0; ns = 0;
        cfg_idx = '0; cfg_last = '0; cfg_addr = '0;
        model_reset();
        clear_counts();
        thr_cyc = 0; sv_cyc = 0;
        repeat (2) @(posedge clk);
        #1;
        for (int k = 0; k < NDUT; k++) chk("reset_outputs", 32'(obs[k]), 32'd0);
        rst = 0;

        // Table {3,7,10}, last stage 2; full window with decisions held high.
        write_entry(0, 3); write_entry(1, 7); write_entry(2, 10); write_last(2);
        clear_counts();
        start = 1; ns = 1; cycle();
        run_idle(100);
        cycle();
        check_order0("s1", 11);
        chk("s1_rom_val", 32'(cnt_val[0]), 32'd8);
        chk("s1_stage_val", 32'(cnt_sv[0]), 32'd3);
        chk("s1_stage_last", 32'(cnt_last[0]), 32'd1);
        chk("s1_done", 32'(cnt_done[0]), 32'd1);
        chk("s1_busy_after", 32'(obs[0][25]), 32'd0);
        chk("s1_cls_before_thr", 32'(cls_before[0]), 32'd3);

        // Stall four cycles while the address sits at 5.
        clear_counts();
        start = 1; ns = 1; cycle();
        n = 0;
        while (m_phase[0] != 0 && n < 100) begin
            wt = (m_phase[0] == 1 && m_addr[0] == 5 && stall5 < 4);
            cycle();
            n++;
        end
        wt = 0;
        run_idle(100);
        cycle();
        chk("s2_stall_cycles", 32'(stall5), 32'd4);
        check_order0("s2", 11);
        chk("s2_rom_val", 32'(cnt_val[0]), 32'd8);
        chk("s2_stage_val", 32'(cnt_sv[0]), 32'd3);

        // Break in the first decide cycle of stage 1 on the latency-2 instance.
        clear_counts();
        start = 1; ns = 1; cycle();
        n = 0;
        while (!(m_phase[1] == 2 && m_stage[1] == 1) && n < 100) begin cycle(); n++; end
        chk("s3_reach_decide", 32'(n < 100), 32'd1);
        n = cnt_sv[1];
        brk = 1; cycle();
        chk("s3_busy_after_break", 32'(obs[1][25]), 32'd0);
        chk("s3_stage_val_after_break", 32'(obs[1][22]), 32'd0);
        ns = 0;
        repeat (3) cycle();
        chk("s3_no_late_returns", 32'(cnt_sv[1]), 32'(n));
        start = 1; cycle();
        chk("s3_restart_busy", 32'(obs[1][25]), 32'd1);
        chk("s3_restart_addr", 32'(obs[1][14:0]), 32'd0);
        chk("s3_restart_stage", 32'(obs[1][19:15]), 32'd0);
        ns = 1;
        run_idle(100);
        cycle();

        // Config write while busy is ignored; the same write in idle takes effect.
        clear_counts();
        start = 1; ns = 1; cycle();
        cycle();
        cfg_we = 1; cfg_idx = '0; cfg_addr = AW'(1); cycle();
        run_idle(100);
        cycle();
        chk("s5_busy_write_ignored", 32'(cls_before[0]), 32'd3);
        write_entry(0, 1);
        clear_counts();
        start = 1; ns = 1; cycle();
        run_idle(100);
        cycle();
        chk("s5_idle_write_used", 32'(cls_before[0]), 32'd1);
        chk("s5_stage_val", 32'(cnt_sv[0]), 32'd3);

        // Latency 3, single stage at address 2: early decision ignored.
        ns = 0;
        write_entry(0, 2); write_last(0);
        clear_counts();
        start = 1; cycle();
        n = 0;
        while (m_phase[2] != 2 && n < 50) begin cycle(); n++; end
        chk("s4_reach_decide", 32'(n < 50), 32'd1);
        ns = 1; cycle();
        ns = 0;
        n = 0;
        while (!obs[2][22] && n < 10) begin cycle(); n++; end
        sv_cyc = cyc;
        chk("s4_stage_val_latency", 32'(sv_cyc - thr_cyc), 32'd3);
        chk("s4_still_busy", 32'(obs[2][25]), 32'd1);
        chk("s4_stage_last", 32'(obs[2][21]), 32'd1);
        ns = 1; cycle();
        chk("s4_done", 32'(obs[2][20]), 32'd1);
        ns = 0;
        run_idle(50);
        cycle();

        // Asynchronous reset in the middle of a window.
        write_entry(0, 3); write_last(2);
        start = 1; cycle();
        repeat (2) cycle();
        #2 rst = 1;
        #1;
        for (int k = 0; k < NDUT; k++) chk("async_reset_outputs", 32'(obs[k]), 32'd0);
        model_reset();
        start = 0; brk = 0; cfg_we = 0; cfg_last_we = 0;
        @(posedge clk);
        #1 rst = 0;
        clear_counts();
        start = 1; ns = 1; cycle();
        run_idle(50);
        cycle();
        chk("reset_table_cleared_thr", 32'(cnt_sv[0]), 32'd1);
        chk("reset_table_cleared_val", 32'(cnt_val[0]), 32'd0);
        check_order0("reset", 1);

        // Randomized windows over random increasing tables.
        for (int r = 0; r < 4; r++) begin
            ns = 0; wt = 0;
            brk = 1; cycle();
            n = 0;
            for (int i = 0; i < 6; i++) begin
                n += int'($urandom_range(1, 4));
                write_entry(i, n);
            end
            write_last(int'($urandom_range(0, 5)));
            for (int c = 0; c < 200; c++) begin
                start = ($urandom % 5) == 0;
                brk   = ($urandom % 50) == 0;
                wt    = ($urandom % 4) == 0;
                ns    = ($urandom % 3) != 0;
                cycle();
            end
        end
        wt = 0; ns = 0;
        brk = 1; cycle();
        cycle();
        hit = 1'b0;
        for (int k = 0; k < NDUT; k++) if (obs[k][25]) hit = 1'b1;
        chk("final_idle", 32'(hit), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/cascade_rom_sequencer.md
Name: cascade_rom_sequencer

Overview:
- Parametrised address sequencer for the classifier-cascade ROM. Walks one detection window through the weak-classifier words of every stage, then the stage-threshold word, then waits for the stage decision.
- Stage-threshold addresses and stage count are written at run time through a config port; no file-loaded table.
- Supports multi-cycle ROM read latency with tagged returns, issue stalls, early reject (break) and an explicit window start/done handshake.
- Sits between the window scheduler (start/break/decision) and the ROM plus weak-classifier evaluator.

Parameters:
- ADDR_WIDTH, 15: ROM address width.
- STAGE_CNT_MAX, 32: threshold-table depth (max stages).
- STAGE_IDX_WIDTH, $clog2(STAGE_CNT_MAX): stage index width (derived).
- ROM_LATENCY, 1: cycles from address issue to data valid; must be ≥1.

Ports:
- clk_i  in  1  clock
- rst_i  in  1  reset, asynchronous, active-high
- cfg_we_i  in  1  write threshold-table entry
- cfg_idx_i  in  STAGE_IDX_WIDTH  table entry index
- cfg_addr_i  in  ADDR_WIDTH  ROM address of that stage's threshold word
- cfg_last_we_i  in  1  write last-stage register
- cfg_last_i  in  STAGE_IDX_WIDTH  index of final stage
- start_i  in  1  begin new window
- break_i  in  1  window rejected; abort
- wait_i  in  1  stall address issue
- next_stage_i  in  1  current stage passed
- busy_o  out  1  sequencer not idle
- rom_addr_o  out  ADDR_WIDTH  ROM address
- rom_req_o  out  1  rom_addr_o is a valid read this cycle
- rom_val_o  out  1  classifier data valid on ROM output
- stage_val_o  out  1  threshold data valid on ROM output
- stage_last_o  out  1  stage_val_o belongs to final stage
- stage_idx_o  out  STAGE_IDX_WIDTH  current stage index
- done_o  out  1  one-cycle pulse: final stage passed

Behaviour:
- Reset: all outputs 0, rom_addr 0, stage 0, table entries 0, last-stage register 0, pipeline valids 0, state IDLE.
- Config:
  - cfg_we_i / cfg_last_we_i are honoured only in IDLE and ignored otherwise.
  - The written value is visible from the next cycle.
- FSM states: IDLE, RUN, DECIDE.
- IDLE:
  - busy_o=0, rom_req_o=0.
  - start_i (with break_i low) → RUN with addr 0, stage 0.
- RUN:
  - rom_req_o = ~wait_i; the address advances by 1 after every issued request.
  - When the issued address equals table[stage], that request is tagged threshold and the FSM goes to DECIDE. The address is held at the threshold address.
  - wait_i=1 holds the address and FSM state; no request is issued; in-flight reads still complete.
- Return pipeline:
  - ROM_LATENCY-deep shift register of {valid, is_threshold}.
  - A request at cycle t produces rom_val_o (classifier) or stage_val_o (threshold) at t+ROM_LATENCY, one cycle wide.
  - stage_last_o = stage_val_o && stage==last.
- DECIDE:
  - rom_req_o=0.
  - next_stage_i is accepted only in or after the cycle stage_val_o is asserted; earlier assertions are ignored.
  - On acceptance with stage==last: done_o pulses next cycle, FSM → IDLE.
  - On acceptance otherwise: stage+1, addr+1, → RUN.
- break_i:
  - Highest priority, any state.
  - Next cycle: FSM IDLE, addr 0, stage 0, all pipeline valids cleared. In-flight returns produce no rom_val_o/stage_val_o.
  - Overrides simultaneous next_stage_i, start_i and wait_i.
- start_i outside IDLE is ignored.
- Address arithmetic is modulo 2^ADDR_WIDTH. Wrap is not expected in valid configs and is not guarded.
- Table entries must be strictly increasing for stages 0..last; behaviour is undefined otherwise.
- Reset mid-operation: immediate return to reset values.

Test Plan:
- ROM_LATENCY=1, table {3,7,10}, last=2; start, next_stage_i asserted with each stage_val_o → requests at addresses 0..10 in order; 8 rom_val_o pulses, 3 stage_val_o pulses; stage_last_o only on the third; done_o one cycle after the third acceptance; busy_o then 0.
- Same config, wait_i held 4 cycles while addr=5 → rom_req_o low 4 cycles, addr stays 5, resumes at 5; no skipped or duplicated address; totals unchanged.
- break_i in DECIDE of stage 1 with a read in flight (ROM_LATENCY=2) → no further rom_val_o/stage_val_o, busy_o=0 next cycle; new start_i re-issues from addr 0, stage_idx_o=0.
- ROM_LATENCY=3, table {2}, last=0: next_stage_i pulsed 1 cycle after threshold request → ignored; stage_val_o exactly 3 cycles after threshold request; next_stage_i then → done_o.
- cfg_we_i writing entry 0=1 while busy → ignored; sequence still uses old value 3. Same write in IDLE → next window thresholds at addr 1.
- rst_i asserted asynchronously mid-RUN → all outputs 0 immediately; after release, IDLE with table cleared.
